saturation_adj: RTL and testbench
=================================

# saturation_adj

Parametrised next-generation RGB saturation stage for the video filter chain. Computes luma Y from programmable coefficients and, per channel, out = Y + (x − Y)·S, where saturation S is a fixed-point gain that may exceed 1.0. Outputs are clamped to the pixel range. Coefficients and mode are double-buffered and change only on a frame boundary (rising edge of vs_i). Sits between the colour-correction and output-formatting stages and carries de/hs/vs with matched latency.

## Interface
- PIXEL_WIDTH, 8, bits per colour channel.
- COE_WIDTH, 16, width of the unsigned coefficient and saturation inputs.
- COE_FRAC, 6, fractional bits of every coefficient; 1.0 = 2^COE_FRAC (64).
- clk  in  1  pixel clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- saturation_i  in  COE_WIDTH  unsigned S; 0 gives grayscale, 1<<COE_FRAC gives identity.
- ycoe0_i / ycoe1_i / ycoe2_i  in  COE_WIDTH each  unsigned luma coefficients for R / G / B.
- bypass_i  in  1  when active, the pixel passes through unmodified with the same latency.
- di_i  in  3*PIXEL_WIDTH  {b,g,r} pixel; r is in the LSBs.
- de_i, hs_i, vs_i  in  1 each  data enable and syncs.
- do_o  out  3*PIXEL_WIDTH  {b,g,r} result.
- de_o, hs_o, vs_o  out  1 each  syncs delayed to align with do_o.

## Operation
- Shadow registers: vs_q is a registered copy of vs_i. When vs_i=1 and vs_q=0 in cycle N, the active set {S, ycoe0..2, bypass} loads from the inputs at the end of cycle N. Pixels presented from cycle N+1 use the new set; the pixel presented in cycle N uses the old set.
- Input changes at any other time have no effect.
- Reset values of the active set: S=1<<COE_FRAC, ycoe=0, bypass=1. The block therefore passes pixels through until the first vs_i rising edge.
- Every pixel carries its own S and bypass values down the pipeline. An update must not alter any pixel already in flight.
- Arithmetic, per pixel:
  - Y_full = (ycoe0·r + ycoe1·g + ycoe2·b) >> COE_FRAC. The sum is unsigned and PIXEL_WIDTH+COE_WIDTH+2 bits wide; the shift truncates.
  - Y = min(Y_full, 2^PIXEL_WIDTH−1).
  - d = x − Y, signed, PIXEL_WIDTH+1 bits.
  - p = d·S, signed, with S zero-extended. The shift is arithmetic (floor toward −∞).
  - o = Y + (p >>> COE_FRAC). The result is clamped to 0 if negative and to 2^PIXEL_WIDTH−1 if above the maximum.
- There is no intermediate overflow: internal widths hold the full product.
- Bypass: do_o equals di_i from the same pipeline slot.
- The datapath computes on every cycle regardless of de_i. de/hs/vs only travel alongside the data.

## Timing
- Latency is fixed at 5 cycles from di_i/de_i/hs_i/vs_i to do_o/de_o/hs_o/vs_o. Throughput is one pixel per clock with no stalls.
- Pipeline stages:
  - S1: the three products.
  - S2: sum, shift and Y clamp.
  - S3: per-channel difference.
  - S4: multiply by S.
  - S5: shift, add and clamp into the output register.
- Reset asserted mid-stream: all pipeline and output registers clear to 0 asynchronously, and the active set returns to its reset values.
- After rst deasserts, the outputs show pipelined zeros until the first real input reaches the output 5 cycles later.
- vs_i held high for several cycles triggers one update only. A vs_i pulse of 1 cycle is sufficient.

## Test plan
Common setup: PIXEL_WIDTH=8, COE_FRAC=6, ycoe=19/38/7 (sum 64), checked 5 cycles after input.
- After reset, with no vs edge yet, di={50,100,200} -> do_o={50,100,200}; de/hs/vs appear 5 cycles later and aligned.
- vs edge loads S=64, bypass=0 -> for random pixels, do_o == di_i exactly. Gray {100,100,100} with any S -> {100,100,100}.
- vs edge loads S=0; input r=200, g=100, b=50 -> Y=124; do_o={124,124,124}.
- vs edge loads S=128; same pixel -> r=255 (clamped from 276), g=76, b=0 (clamped from −24); do_o={0,76,255}.
- ycoe=32/32/32 with S=0; input {255,255,255} -> Y clamps from 382 to 255; do_o={255,255,255}.
- Continuous stream of input r=200, g=100, b=50; vs_i pulses at cycle N while saturation_i changes 64->0; saturation_i is also changed mid-frame without a vs edge:
  - Pixels entered ≤N exit unmodified.
  - Pixels entered ≥N+1 exit as {124,124,124}.
  - The mid-frame change is ignored.
  - rst pulsed mid-stream zeroes all outputs immediately and restores bypass.

Source files
------------

// File: rtl/saturation_adj.sv
// saturation_adj: RGB saturation stage. Computes luma from programmable
// coefficients and scales each channel's distance from luma by S, with the
// result clamped to the pixel range. The coefficient/saturation/bypass set
// is double-buffered and only reloads on a rising edge of vs_i. Every pixel
// carries its own S and bypass down the 5-stage pipeline, so a reload never
// disturbs pixels already in flight.
module saturation_adj #(
  parameter int PIXEL_WIDTH = 8,
  parameter int COE_WIDTH   = 16,
  parameter int COE_FRAC    = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COE_WIDTH-1:0]     saturation_i,
  input  logic [COE_WIDTH-1:0]     ycoe0_i,
  input  logic [COE_WIDTH-1:0]     ycoe1_i,
  input  logic [COE_WIDTH-1:0]     ycoe2_i,
  input  logic                     bypass_i,
  input  logic [3*PIXEL_WIDTH-1:0] di_i,
  input  logic                     de_i,
  input  logic                     hs_i,
  input  logic                     vs_i,
  output logic [3*PIXEL_WIDTH-1:0] do_o,
  output logic                     de_o,
  output logic                     hs_o,
  output logic                     vs_o
);

  localparam int PW   = PIXEL_WIDTH;
  localparam int CW   = COE_WIDTH;
  localparam int CF   = COE_FRAC;
  localparam int PRW  = PW + CW;       // one coefficient product
  localparam int SUMW = PW + CW + 2;   // sum of three products
  localparam int DW   = PW + 1;        // signed channel minus luma
  localparam int MW   = DW + CW + 1;   // signed difference times zero-extended S
  localparam int OW   = MW + 1;        // luma plus scaled difference

  // Active (shadow) parameter set
  logic          vs_q;
  logic [CW-1:0] sat_act;
  logic [CW-1:0] coe_act [3];
  logic          byp_act;

  // Pipeline registers
  logic [PRW-1:0]       s1_prod [3];
  logic [3*PW-1:0]      s1_x;
  logic [CW-1:0]        s1_s;
  logic                 s1_b;
  logic [PW-1:0]        s2_y;
  logic [3*PW-1:0]      s2_x;
  logic [CW-1:0]        s2_s;
  logic                 s2_b;
  logic signed [DW-1:0] s3_d [3];
  logic [PW-1:0]        s3_y;
  logic [3*PW-1:0]      s3_x;
  logic [CW-1:0]        s3_s;
  logic                 s3_b;
  logic signed [MW-1:0] s4_p [3];
  logic [PW-1:0]        s4_y;
  logic [3*PW-1:0]      s4_x;
  logic                 s4_b;
  logic [2:0]           sync_sr [5];

  // Combinational intermediates
  logic [SUMW-1:0] y_sum;
  logic [SUMW-1:0] y_full;
  logic [PW-1:0]   y_sat;
  logic [3*PW-1:0] s5_res;

  // Reload the active set on the first cycle vs_i is seen high after being low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q    <= 1'b0;
      sat_act <= CW'(1 << CF);
      for (int k = 0; k < 3; k++) coe_act[k] <= '0;
      byp_act <= 1'b1;
    end else begin
      vs_q <= vs_i;
      if (vs_i && !vs_q) begin
        sat_act    <= saturation_i;
        coe_act[0] <= ycoe0_i;
        coe_act[1] <= ycoe1_i;
        coe_act[2] <= ycoe2_i;
        byp_act    <= bypass_i;
      end
    end
  end

  // Stage 1: per-channel luma products, tagging the pixel with the current set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) s1_prod[k] <= '0;
      s1_x <= '0;
      s1_s <= '0;
      s1_b <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++)
        s1_prod[k] <= PRW'(coe_act[k]) * PRW'(di_i[k*PW +: PW]);
      s1_x <= di_i;
      s1_s <= sat_act;
      s1_b <= byp_act;
    end
  end

  // Luma sum, truncating fixed-point shift and saturation to the pixel range
  always_comb begin
    y_sum  = SUMW'(s1_prod[0]) + SUMW'(s1_prod[1]) + SUMW'(s1_prod[2]);
    y_full = y_sum >> CF;
    y_sat  = y_full[PW-1:0];
    if (|y_full[SUMW-1:PW]) y_sat = '1;
  end

  // Stages 2 and 3: register luma, then the signed per-channel difference
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_y <= '0;
      s2_x <= '0;
      s2_s <= '0;
      s2_b <= 1'b0;
      for (int k = 0; k < 3; k++) s3_d[k] <= '0;
      s3_y <= '0;
      s3_x <= '0;
      s3_s <= '0;
      s3_b <= 1'b0;
    end else begin
      s2_y <= y_sat;
      s2_x <= s1_x;
      s2_s <= s1_s;
      s2_b <= s1_b;
      for (int k = 0; k < 3; k++)
        s3_d[k] <= $signed({1'b0, s2_x[k*PW +: PW]}) - $signed({1'b0, s2_y});
      s3_y <= s2_y;
      s3_x <= s2_x;
      s3_s <= s2_s;
      s3_b <= s2_b;
    end
  end

  // Stage 4: scale each difference by the pixel's own saturation gain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) s4_p[k] <= '0;
      s4_y <= '0;
      s4_x <= '0;
      s4_b <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++)
        s4_p[k] <= MW'(s3_d[k]) * MW'($signed({1'b0, s3_s}));
      s4_y <= s3_y;
      s4_x <= s3_x;
      s4_b <= s3_b;
    end
  end

  // Floor-shift the scaled difference, add luma back and clamp each channel
  always_comb begin : s5_calc
    logic signed [MW-1:0] sh;
    logic signed [OW-1:0] t;
    s5_res = '0;
    for (int k = 0; k < 3; k++) begin
      sh = s4_p[k] >>> CF;
      t  = $signed({{(OW-PW){1'b0}}, s4_y}) + $signed({sh[MW-1], sh});
      if (t[OW-1])
        s5_res[k*PW +: PW] = '0;
      else if (|t[OW-2:PW])
        s5_res[k*PW +: PW] = '1;
      else
        s5_res[k*PW +: PW] = t[PW-1:0];
    end
  end

  // Stage 5: output register, selecting the untouched pixel when bypassed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) do_o <= '0;
    else     do_o <= s4_b ? s4_x : s5_res;
  end

  // Delay de/hs/vs by the same five stages as the pixel data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 5; k++) sync_sr[k] <= '0;
    end else begin
      sync_sr[0] <= {de_i, hs_i, vs_i};
      for (int k = 1; k < 5; k++) sync_sr[k] <= sync_sr[k-1];
    end
  end

  assign {de_o, hs_o, vs_o} = sync_sr[4];

endmodule

// File: tb/tb_saturation_adj.sv
// Testbench for saturation_adj: stimulus pushes the expected output of each
// pixel (from an arithmetic reference model) into a queue, tagged with the
// cycle it should emerge; a monitor pops and compares on the falling edge.
module tb_saturation_adj;

  localparam int PW   = 8;
  localparam int CW   = 16;
  localparam int CF   = 6;
  localparam int LAT  = 5;
  localparam int MAXV = (1 << PW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [CW-1:0]   saturation_i, ycoe0_i, ycoe1_i, ycoe2_i;
  logic            bypass_i;
  logic [3*PW-1:0] di_i;
  logic            de_i, hs_i, vs_i;
  logic [3*PW-1:0] do_o;
  logic            de_o, hs_o, vs_o;

  saturation_adj #(.PIXEL_WIDTH(PW), .COE_WIDTH(CW), .COE_FRAC(CF)) dut (
    .clk(clk), .rst(rst), .saturation_i(saturation_i),
    .ycoe0_i(ycoe0_i), .ycoe1_i(ycoe1_i), .ycoe2_i(ycoe2_i),
    .bypass_i(bypass_i), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [26:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Values presented on the programming inputs
  int progS, progC0, progC1, progC2;
  bit progByp;
  // Reference model of the active set and of the previous vs
  longint mS, mC0, mC1, mC2;
  bit     mByp, mVsq;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] refPixel(input logic [23:0] px, input longint s,
                                           input longint c0, input longint c1,
                                           input longint c2, input bit byp);
    longint xs [3];
    longint y, d, p, q, o;
    logic [23:0] r;
    if (byp) return px;
    for (int ch = 0; ch < 3; ch++) xs[ch] = px[ch*PW +: PW];
    y = (c0 * xs[0] + c1 * xs[1] + c2 * xs[2]) / (1 << CF);
    if (y > MAXV) y = MAXV;
    r = '0;
    for (int ch = 0; ch < 3; ch++) begin
      d = xs[ch] - y;
      p = d * s;
      q = (p >= 0) ? p / (1 << CF) : -((-p + (1 << CF) - 1) / (1 << CF));
      o = y + q;
      if (o < 0) o = 0;
      if (o > MAXV) o = MAXV;
      r[ch*PW +: PW] = 8'(o);
    end
    return r;
  endfunction

  task automatic modelReset();
    mS = 1 << CF; mC0 = 0; mC1 = 0; mC2 = 0; mByp = 1'b1; mVsq = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [26:0] act, input logic [26:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got do=%h de/hs/vs=%b, want do=%h de/hs/vs=%b",
               name, cyc, act[26:3], act[2:0], exp[26:3], exp[2:0]);
    end
  endtask

  // Drive one pixel for one clock and record what must come out LAT cycles later
  task automatic applyStimulus(input logic [23:0] px, input bit de, input bit hs, input bit vs);
    exp_t e;
    @(posedge clk);
    #1;
    di_i = px; de_i = de; hs_i = hs; vs_i = vs;
    saturation_i = 16'(progS);
    ycoe0_i = 16'(progC0); ycoe1_i = 16'(progC1); ycoe2_i = 16'(progC2);
    bypass_i = progByp;
    e.due = cyc + LAT;
    e.exp = {refPixel(px, mS, mC0, mC1, mC2, mByp), de, hs, vs};
    sbq.push_back(e);
    if (vs && !mVsq) begin
      mS = progS; mC0 = progC0; mC1 = progC1; mC2 = progC2; mByp = progByp;
    end
    mVsq = vs;
  endtask

  task automatic frameEdge(input logic [23:0] px);
    applyStimulus(px, 1'b0, 1'b0, 1'b1);
    applyStimulus(px, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    sbq.delete();
    #1;
    checkOutput("reset_clear", {do_o, de_o, hs_o, vs_o}, 27'd0);
    di_i = '0; de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold", {do_o, de_o, hs_o, vs_o}, 27'd0);
    rst = 1'b0;
    modelReset();
  endtask

  // Monitor: compare every queued expectation on the cycle it falls due
  always @(negedge clk) begin
    if (!rst) begin
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        exp_t e;
        e = sbq.pop_front();
        if (e.due < cyc) begin
          checks++;
          errors++;
          $display("[TB] FAIL missed_slot: due %0d, now %0d", e.due, cyc);
        end else begin
          checkOutput("pixel", {do_o, de_o, hs_o, vs_o}, e.exp);
        end
      end
    end
  end

  localparam logic [23:0] PIX_RGB = {8'd50, 8'd100, 8'd200};

  initial begin
    rst = 1'b1;
    di_i = '0; de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    progS = 64; progC0 = 19; progC1 = 38; progC2 = 7; progByp = 1'b0;
    saturation_i = 16'(progS); ycoe0_i = 16'(progC0); ycoe1_i = 16'(progC1);
    ycoe2_i = 16'(progC2); bypass_i = progByp;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", {do_o, de_o, hs_o, vs_o}, 27'd0);
    rst = 1'b0;

    // No vs edge yet: programming inputs are ignored, pixels pass through
    for (int i = 0; i < 8; i++) applyStimulus(PIX_RGB, 1'b1, i == 0, 1'b0);

    // Identity gain: output equals input for random pixels
    frameEdge(PIX_RGB);
    for (int i = 0; i < 20; i++) applyStimulus(24'($urandom()), 1'($urandom()), 1'($urandom()), 1'b0);

    // Gray pixels are unaffected by any gain
    for (int i = 0; i < 4; i++) begin
      progS = $urandom_range(0, 1000);
      frameEdge(24'h646464);
      repeat (3) applyStimulus(24'h646464, 1'b1, 1'b0, 1'b0);
    end

    // Grayscale, then boosted saturation with clamping both ways
    progS = 0;
    frameEdge(PIX_RGB);
    repeat (4) applyStimulus(PIX_RGB, 1'b1, 1'b0, 1'b0);
    progS = 128;
    frameEdge(PIX_RGB);
    repeat (4) applyStimulus(PIX_RGB, 1'b1, 1'b0, 1'b0);

    // Luma overflow clamps to the pixel maximum
    progS = 0; progC0 = 32; progC1 = 32; progC2 = 32;
    frameEdge(24'hFFFFFF);
    repeat (4) applyStimulus(24'hFFFFFF, 1'b1, 1'b0, 1'b0);

    // Continuous stream: frame-boundary update, ignored mid-frame change,
    // and vs held high for several cycles giving only one reload
    progS = 64; progC0 = 19; progC1 = 38; progC2 = 7;
    frameEdge(PIX_RGB);
    repeat (8) applyStimulus(PIX_RGB, 1'b1, 1'b0, 1'b0);
    progS = 0;
    applyStimulus(PIX_RGB, 1'b1, 1'b0, 1'b1);
    repeat (8) applyStimulus(PIX_RGB, 1'b1, 1'b0, 1'b0);
    progS = 200;
    repeat (8) applyStimulus(PIX_RGB, 1'b1, 1'b0, 1'b0);
    progS = 128;
    applyStimulus(PIX_RGB, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      progS = $urandom_range(0, 300);
      applyStimulus(PIX_RGB, 1'b0, 1'b0, 1'b1);
    end
    repeat (8) applyStimulus(PIX_RGB, 1'b1, 1'b0, 1'b0);

    // Mid-stream reset clears outputs and restores pass-through
    doReset();
    repeat (10) applyStimulus(24'($urandom()), 1'b1, 1'b0, 1'b0);

    // Randomised programming, pixels and vs activity
    for (int i = 0; i < 300; i++) begin
      progS   = ($urandom_range(0, 15) == 0) ? 65535 : $urandom_range(0, 300);
      progC0  = $urandom_range(0, 80);
      progC1  = $urandom_range(0, 80);
      progC2  = $urandom_range(0, 80);
      progByp = ($urandom_range(0, 3) == 0);
      applyStimulus(24'($urandom()), 1'($urandom()), 1'($urandom()),
                    ($urandom_range(0, 5) == 0));
    end

    // Drain the pipeline with a bounded wait
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expected pixels never compared, want 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
